// File: rtl/bmlp_pkg.sv
// Shared types and arithmetic for the Binary-MLP layer blocks.
package bmlp_pkg;

   typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

   localparam logic [6:0] TERM_NEG1 = 7'h7F;
   localparam logic [6:0] TERM_POS1 = 7'h01;
   localparam logic [6:0] TERM_ZERO = 7'h00;

   // Signed add of two 32-bit operands, clamped to the range of a w-bit signed value (w <= 32).
   function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                  input logic signed [31:0] b,
                                                  input int w);
      logic signed [32:0] s;
      logic signed [32:0] hi;
      logic signed [32:0] lo;
      s  = 33'(a) + 33'(b);
      hi = (33'sd1 <<< (w - 1)) - 33'sd1;
      lo = -(33'sd1 <<< (w - 1));
      if (s > hi)
         return hi[31:0];
      else if (s < lo)
         return lo[31:0];
      else
         return s[31:0];
   endfunction

endpackage

// File: rtl/bnn_sat_acc.sv
// Saturating signed accumulator: loads a start value, then adds sign-extended terms without wrapping.
module bnn_sat_acc
   import bmlp_pkg::*;
#(
   parameter int TERM_W = 7,
   parameter int ACC_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic [ACC_W-1:0]  load_val,
   input  logic              en,
   input  logic [TERM_W-1:0] term,
   output logic [ACC_W-1:0]  acc
);

   logic [ACC_W-1:0] sum;

   assign sum = ACC_W'(sat_add(32'(signed'(acc)), 32'(signed'(term)), ACC_W));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         acc <= '0;
      else if (load)
         acc <= load_val;
      else if (en)
         acc <= sum;
   end

endmodule

// File: rtl/bnn_neuron_acc.sv
// One neuron lane: sums N_INPUTS product terms onto a bias and emits the sign bit plus the saturated sum.
module bnn_neuron_acc
   import bmlp_pkg::*;
#(
   parameter int TERM_W   = 7,
   parameter int N_INPUTS = 784,
   parameter int ACC_W    = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ACC_W-1:0]  bias,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [TERM_W-1:0] in_term,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_bit,
   output logic [ACC_W-1:0]  out_sum,
   output logic              busy
);

   localparam int CNT_W = $clog2(N_INPUTS);

   state_t           state;
   state_t           state_next;
   logic [CNT_W-1:0] cnt;
   logic [ACC_W-1:0] acc;
   logic [ACC_W-1:0] final_sum;
   logic             load;
   logic             en;
   logic             last_term;

   bnn_sat_acc #(
      .TERM_W (TERM_W),
      .ACC_W  (ACC_W)
   ) u_acc (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (load),
      .load_val (bias),
      .en       (en),
      .term     (in_term),
      .acc      (acc)
   );

   // Same sum the accumulator will store on this accept, captured as the result on the last term.
   assign final_sum = ACC_W'(sat_add(32'(signed'(acc)), 32'(signed'(in_term)), ACC_W));
   assign last_term = (cnt == CNT_W'(N_INPUTS - 1));

   assign in_ready  = (state == ACCUM);
   assign out_valid = (state == DONE);
   assign busy      = (state != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      load       = 1'b0;
      en         = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               load       = 1'b1;
               state_next = ACCUM;
            end
         end
         ACCUM: begin
            if (in_valid) begin
               en = 1'b1;
               if (last_term)
                  state_next = DONE;
            end
         end
         DONE: begin
            // A start coinciding with the handshake chains straight into the next neuron.
            if (out_ready) begin
               if (start) begin
                  load       = 1'b1;
                  state_next = ACCUM;
               end else begin
                  state_next = IDLE;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt <= '0;
      else if (load)
         cnt <= '0;
      else if (en)
         cnt <= cnt + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_sum <= '0;
         out_bit <= 1'b0;
      end else if (en && last_term) begin
         out_sum <= final_sum;
         out_bit <= ~final_sum[ACC_W-1];
      end
   end

endmodule

// File: tb/tb_bnn_neuron_acc.sv
// Randomised scoreboard bench for bnn_neuron_acc with a plain-arithmetic saturating-sum reference.
module tb_bnn_neuron_acc;

   localparam int N  = 4;
   localparam int TW = 7;
   localparam int AW = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [AW-1:0] bias = '0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [TW-1:0] in_term = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic          out_bit;
   logic [AW-1:0] out_sum;
   logic          busy;

   bnn_neuron_acc #(.TERM_W(TW), .N_INPUTS(N), .ACC_W(AW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .bias      (bias),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_term   (in_term),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_bit   (out_bit),
      .out_sum   (out_sum),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      int sum;
      int sbit;
   } exp_t;

   exp_t          q[$];
   int            errors = 0;
   int            checks = 0;
   logic [TW-1:0] cur[N];

   task automatic chk(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   // Reference: sum in unbounded integers, clamped to the AW-bit signed range after every term.
   function automatic int clamp(input int v);
      int hi = (1 << (AW - 1)) - 1;
      int lo = -(1 << (AW - 1));
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction

   function automatic int sext_term(input logic [TW-1:0] t);
      return int'($signed(t));
   endfunction

   // Monitor: compares every handshaken result against the oldest expected entry.
   int            acc_cnt = 0;
   bit            hold = 1'b0;
   logic [AW-1:0] held_sum;
   logic          held_bit;
   always @(negedge clk) begin
      if (!rst_n) begin
         acc_cnt = 0;
         hold    = 1'b0;
      end else begin
         if (in_valid && in_ready) acc_cnt++;
         if (out_valid) begin
            if (hold) begin
               chk("hold_sum", int'($signed(out_sum)), int'($signed(held_sum)));
               chk("hold_bit", int'(out_bit), int'(held_bit));
            end
            if (out_ready) begin
               if (q.size() == 0) begin
                  chk("unexpected_output", 1, 0);
               end else begin
                  exp_t e;
                  e = q.pop_front();
                  chk("out_sum", int'($signed(out_sum)), e.sum);
                  chk("out_bit", int'(out_bit), e.sbit);
                  $display("result sum=%0d bit=%0b (expected %0d/%0d)",
                           $signed(out_sum), out_bit, e.sum, e.sbit);
               end
               chk("accepts_per_eval", acc_cnt, N);
               acc_cnt = 0;
               hold    = 1'b0;
            end else begin
               hold     = 1'b1;
               held_sum = out_sum;
               held_bit = out_bit;
            end
         end else begin
            hold = 1'b0;
         end
      end
   end

   // gap < 0 selects a random gap of 0..2 idle cycles before each term.
   task automatic do_eval(input int b, input bit started, input int gap);
      int s;
      int g;
      int k;
      bit r;
      if (!started) begin
         start = 1'b1;
         bias  = AW'(b);
         @(posedge clk); #1;
         start = 1'b0;
      end
      chk("accum_ready", int'(in_ready), 1);
      s = b;
      for (int i = 0; i < N; i++) begin
         g = (gap < 0) ? int'($urandom_range(2, 0)) : gap;
         for (int j = 0; j < g; j++) begin
            in_valid = 1'b0;
            in_term  = TW'($urandom);
            @(posedge clk); #1;
            chk("ready_in_gap", int'(in_ready), 1);
         end
         in_valid = 1'b1;
         in_term  = cur[i];
         k = 0;
         r = 1'b0;
         do begin
            @(negedge clk);
            r = in_ready;
            @(posedge clk); #1;
            k++;
         end while (!r && k < 100);
         if (!r) chk("accept_timeout", 0, 1);
         s = clamp(s + sext_term(cur[i]));
      end
      in_valid = 1'b0;
      q.push_back('{sum: s, sbit: (s >= 0) ? 1 : 0});
      chk("latency_valid", int'(out_valid), 1);
   endtask

   task automatic release_out(input int d, input bit chain, input int nb);
      int k = 0;
      while (!out_valid && k < 100) begin
         @(posedge clk); #1;
         k++;
      end
      chk("wait_valid", int'(out_valid), 1);
      for (int i = 0; i < d; i++) begin
         start    = 1'b1;
         bias     = AW'($urandom);
         in_valid = 1'b1;
         in_term  = bmlp_pkg::TERM_POS1;
         @(posedge clk); #1;
         chk("done_ready_low", int'(in_ready), 0);
         chk("done_valid_held", int'(out_valid), 1);
      end
      out_ready = 1'b1;
      start     = chain;
      bias      = AW'(nb);
      in_valid  = 1'b0;
      @(posedge clk); #1;
      out_ready = 1'b0;
      start     = 1'b0;
      if (chain) chk("chain_accum", int'(in_ready), 1);
      else       chk("back_idle", int'(busy), 0);
   endtask

   task automatic check_zero_outputs(input string tag);
      chk({tag, "_in_ready"}, int'(in_ready), 0);
      chk({tag, "_out_valid"}, int'(out_valid), 0);
      chk({tag, "_out_bit"}, int'(out_bit), 0);
      chk({tag, "_out_sum"}, int'(out_sum), 0);
      chk({tag, "_busy"}, int'(busy), 0);
   endtask

   initial begin
      bit chained;
      int b;
      int nb;

      repeat (3) @(posedge clk);
      #1;
      check_zero_outputs("reset");
      rst_n = 1'b1;

      // IDLE must not consume offered terms.
      in_valid = 1'b1;
      in_term  = bmlp_pkg::TERM_POS1;
      repeat (3) begin
         @(posedge clk); #1;
         chk("idle_ready_low", int'(in_ready), 0);
      end
      in_valid = 1'b0;

      cur = '{bmlp_pkg::TERM_POS1, bmlp_pkg::TERM_POS1, bmlp_pkg::TERM_NEG1, bmlp_pkg::TERM_POS1};
      do_eval(0, 1'b0, 0);
      release_out(0, 1'b0, 0);

      cur = '{bmlp_pkg::TERM_POS1, bmlp_pkg::TERM_ZERO, bmlp_pkg::TERM_POS1, bmlp_pkg::TERM_POS1};
      do_eval(-3, 1'b0, 2);
      release_out(0, 1'b0, 0);

      cur = '{bmlp_pkg::TERM_POS1, bmlp_pkg::TERM_POS1, bmlp_pkg::TERM_POS1, bmlp_pkg::TERM_POS1};
      do_eval(126, 1'b0, 0);
      release_out(1, 1'b0, 0);

      cur = '{bmlp_pkg::TERM_NEG1, bmlp_pkg::TERM_NEG1, bmlp_pkg::TERM_NEG1, bmlp_pkg::TERM_NEG1};
      do_eval(-127, 1'b0, 0);
      release_out(5, 1'b1, 10);

      cur = '{bmlp_pkg::TERM_NEG1, bmlp_pkg::TERM_NEG1, bmlp_pkg::TERM_POS1, bmlp_pkg::TERM_NEG1};
      do_eval(10, 1'b1, 1);
      release_out(0, 1'b0, 0);

      // Abort an evaluation halfway with reset.
      start    = 1'b1;
      bias     = AW'(5);
      @(posedge clk); #1;
      start    = 1'b0;
      in_valid = 1'b1;
      in_term  = bmlp_pkg::TERM_POS1;
      repeat (2) begin
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      rst_n    = 1'b0;
      #1;
      check_zero_outputs("abort");
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (3) begin
         @(posedge clk); #1;
      end
      chk("abort_no_valid", int'(out_valid), 0);

      cur = '{bmlp_pkg::TERM_NEG1, bmlp_pkg::TERM_NEG1, bmlp_pkg::TERM_NEG1, bmlp_pkg::TERM_NEG1};
      do_eval(0, 1'b0, 0);
      release_out(2, 1'b0, 0);

      chained = 1'b0;
      nb      = 0;
      for (int it = 0; it < 24; it++) begin
         b = chained ? nb : int'($urandom_range(255, 0)) - 128;
         for (int i = 0; i < N; i++) cur[i] = TW'($urandom);
         do_eval(b, chained, -1);
         nb      = int'($urandom_range(255, 0)) - 128;
         chained = (it == 23) ? 1'b0 : 1'($urandom_range(1, 0));
         release_out(int'($urandom_range(3, 0)), chained, nb);
      end

      repeat (5) @(posedge clk);
      #1;
      chk("queue_empty", q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
